// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the multi-cycle MIPS sequencer.
// This file holds the opcode/funct codes, state encodings, PCSrc codes and the instruction-class record.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'd0,
    PC_BRANCH = 2'd1,
    PC_REG    = 2'd2,
    PC_JUMP   = 2'd3
  } pcsrc_t;

  // One-hot instruction class; exactly one bit is set for any opcode/funct pair.
  typedef struct packed {
    logic rtype;
    logic jr;
    logic j;
    logic jal;
    logic branch;
    logic imm;
    logic load;
    logic store;
    logic halt;
    logic illegal;
  } insn_class_t;

endpackage

// File: rtl/insn_class_decode.sv
// Combinational opcode/funct decode into a one-hot instruction class.
// Any R-type funct other than jr is treated as an ordinary ALU instruction.
module insn_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output insn_class_t cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JR) cls.jr = 1'b1;
        else                cls.rtype = 1'b1;
      end
      OP_J:           cls.j = 1'b1;
      OP_JAL:         cls.jal = 1'b1;
      OP_BEQ, OP_BNE: cls.branch = 1'b1;
      OP_ADDI, OP_ORI: cls.imm = 1'b1;
      OP_LW:          cls.load = 1'b1;
      OP_SW:          cls.store = 1'b1;
      OP_HALT:        cls.halt = 1'b1;
      default:        cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle IF/ID/EXE/MEM/WB control FSM with next-PC select, strobes and retired counter.
// Optional jr target alignment check is enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 3
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               imemReady,
  input  logic               dmemReady,
`ifdef PC_ALIGN_CHECK_EN
  input  logic [1:0]         regSrcLow,
  output logic               alignErr,
`endif
  output logic               PCWrite,
  output logic [1:0]         PCSrc,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [STATE_W-1:0] state,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  insn_class_t      cls;
  state_t           st_q, st_nxt;
  logic [CNT_W-1:0] retired_q;
  logic             pcw, irw, rw, mr, mw;
  pcsrc_t           src;
  logic             align_fault;

  insn_class_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  always_comb begin
    st_nxt      = st_q;
    pcw         = 1'b0;
    src         = PC_NEXT;
    irw         = 1'b0;
    rw          = 1'b0;
    mr          = 1'b0;
    mw          = 1'b0;
    align_fault = 1'b0;
    case (st_q)
      S_IF: begin
        if (imemReady) begin
          irw    = 1'b1;
          st_nxt = S_ID;
        end
      end
      S_ID: begin
        if (cls.j || cls.jal) begin
          pcw    = 1'b1;
          src    = PC_JUMP;
          rw     = cls.jal;
          st_nxt = S_IF;
        end else if (cls.jr) begin
`ifdef PC_ALIGN_CHECK_EN
          if (regSrcLow != 2'b00) begin
            align_fault = 1'b1;
            st_nxt      = S_HALT;
          end else begin
            pcw    = 1'b1;
            src    = PC_REG;
            st_nxt = S_IF;
          end
`else
          pcw    = 1'b1;
          src    = PC_REG;
          st_nxt = S_IF;
`endif
        end else if (cls.halt) begin
          st_nxt = S_HALT;
        end else if (cls.illegal) begin
          pcw    = 1'b1;
          st_nxt = S_IF;
        end else begin
          st_nxt = S_EXE;
        end
      end
      S_EXE: begin
        if (cls.branch) begin
          pcw    = 1'b1;
          // bne takes on a clear zero flag, beq on a set one
          src    = ((opcode == OP_BNE) ? !zero : zero) ? PC_BRANCH : PC_NEXT;
          st_nxt = S_IF;
        end else if (cls.rtype || cls.imm) begin
          st_nxt = S_WB;
        end else if (cls.load || cls.store) begin
          st_nxt = S_MEM;
        end else begin
          st_nxt = S_IF;
        end
      end
      S_MEM: begin
        if (cls.store) begin
          mw = 1'b1;
          if (dmemReady) begin
            pcw    = 1'b1;
            st_nxt = S_IF;
          end
        end else begin
          mr = 1'b1;
          if (dmemReady) st_nxt = S_WB;
        end
      end
      S_WB: begin
        rw     = 1'b1;
        pcw    = 1'b1;
        st_nxt = S_IF;
      end
      S_HALT: st_nxt = S_HALT;
      default: st_nxt = S_IF;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      st_q      <= S_IF;
      retired_q <= '0;
    end else begin
      st_q <= st_nxt;
      if (pcw) retired_q <= retired_q + 1'b1;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic align_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)           align_q <= 1'b0;
    else if (align_fault) align_q <= 1'b1;
  end

  assign alignErr = align_q && (st_q == S_HALT) && Reset;
`else
  logic unused_align;
  assign unused_align = align_fault;
`endif

  // Strobes are suppressed while Reset is held so nothing fires during the async reset window.
  assign PCWrite  = pcw && Reset;
  assign PCSrc    = Reset ? src : PC_NEXT;
  assign IRWrite  = irw && Reset;
  assign RegWrite = rw && Reset;
  assign MemRead  = mr && Reset;
  assign MemWrite = mw && Reset;
  assign halted   = (st_q == S_HALT) && Reset;
  assign state    = STATE_W'(st_q);
  assign retired  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected per-cycle outputs, a negedge monitor pops and compares.
// Define PC_ALIGN_CHECK_EN to also exercise the jr alignment fault path.
module tb_pc_sequencer;

  localparam logic [5:0] R_OP = 6'b000000;
  localparam logic [5:0] J_OP = 6'b000010;
  localparam logic [5:0] JAL  = 6'b000011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] HLT  = 6'b111111;
  localparam logic [5:0] ILL  = 6'b010000;
  localparam logic [5:0] FJR  = 6'b001000;
  localparam logic [5:0] FADD = 6'b100000;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [5:0]  opcode = '0, funct = '0;
  logic        zero = 1'b0, imemReady = 1'b0, dmemReady = 1'b0;
  logic        PCWrite, IRWrite, RegWrite, MemRead, MemWrite, halted;
  logic [1:0]  PCSrc;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        aerr_dut;
`ifdef PC_ALIGN_CHECK_EN
  logic [1:0]  regSrcLow = 2'b00;
  logic        alignErr;
  assign aerr_dut = alignErr;
`else
  assign aerr_dut = 1'b0;
`endif

  pc_sequencer #(.CNT_W(32), .STATE_W(3)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .imemReady (imemReady),
    .dmemReady (dmemReady),
`ifdef PC_ALIGN_CHECK_EN
    .regSrcLow (regSrcLow),
    .alignErr  (alignErr),
`endif
    .PCWrite   (PCWrite),
    .PCSrc     (PCSrc),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .state     (state),
    .halted    (halted),
    .retired   (retired)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [43:0] vec;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = '0;
  logic        exp_aerr = 1'b0;

  // Expected vector layout: state, PCWrite, PCSrc, IRWrite, RegWrite, MemRead, MemWrite, halted, alignErr, retired
  task automatic push(input string nm, input logic [2:0] st, input logic pcw, input logic [1:0] src,
                      input logic irw, rw, mr, mw, hlt);
    exp_t e;
    e.name = nm;
    e.vec  = {st, pcw, src, irw, rw, mr, mw, hlt, exp_aerr, exp_ret};
    q.push_back(e);
    if (pcw) exp_ret = exp_ret + 1;
  endtask

  task automatic cyc(input string nm, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, im, dm, input logic [2:0] st, input logic pcw,
                     input logic [1:0] src, input logic irw, rw, mr, mw, hlt);
    @(posedge CLK); #1;
    Reset = 1'b1; opcode = op; funct = fn; zero = z; imemReady = im; dmemReady = dm;
    push(nm, st, pcw, src, irw, rw, mr, mw, hlt);
  endtask

  // Reset asserted with both ready lines high: every strobe must still be quiet.
  task automatic rst_cyc(input string nm);
    @(posedge CLK); #1;
    Reset = 1'b0; imemReady = 1'b1; dmemReady = 1'b1;
    exp_ret = '0; exp_aerr = 1'b0;
    push(nm, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [43:0] got;
      e = q.pop_front();
      got = {state, PCWrite, PCSrc, IRWrite, RegWrite, MemRead, MemWrite, halted, aerr_dut, retired};
      checks++;
      if (got !== e.vec) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, got, e.vec);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog queue=%0d", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst_cyc("rst0");
    rst_cyc("rst1");
    // addi: IF, ID, EXE, WB
    cyc("addi_if",  ADDI, 0, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    cyc("addi_id",  ADDI, 0, 0,1,1, 3'd1, 0,2'd0, 0,0,0,0,0);
    cyc("addi_exe", ADDI, 0, 0,1,1, 3'd2, 0,2'd0, 0,0,0,0,0);
    cyc("addi_wb",  ADDI, 0, 0,1,0, 3'd4, 1,2'd0, 0,1,0,0,0);
    // IF stalls while the instruction word is not ready
    cyc("if_hold0", BEQ, 0, 0,0,1, 3'd0, 0,2'd0, 0,0,0,0,0);
    cyc("if_hold1", BEQ, 0, 0,0,0, 3'd0, 0,2'd0, 0,0,0,0,0);
    cyc("beqt_if",  BEQ, 0, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    cyc("beqt_id",  BEQ, 0, 1,1,0, 3'd1, 0,2'd0, 0,0,0,0,0);
    cyc("beqt_exe", BEQ, 0, 1,1,0, 3'd2, 1,2'd1, 0,0,0,0,0);
    cyc("beqn_if",  BEQ, 0, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    cyc("beqn_id",  BEQ, 0, 0,1,0, 3'd1, 0,2'd0, 0,0,0,0,0);
    cyc("beqn_exe", BEQ, 0, 0,1,0, 3'd2, 1,2'd0, 0,0,0,0,0);
    cyc("bnet_if",  BNE, 0, 1,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    cyc("bnet_id",  BNE, 0, 1,1,0, 3'd1, 0,2'd0, 0,0,0,0,0);
    cyc("bnet_exe", BNE, 0, 0,1,0, 3'd2, 1,2'd1, 0,0,0,0,0);
    // lw with three wait cycles: 8 cycles total
    cyc("lw_if",    LW, 0, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    cyc("lw_id",    LW, 0, 0,1,1, 3'd1, 0,2'd0, 0,0,0,0,0);
    cyc("lw_exe",   LW, 0, 0,1,1, 3'd2, 0,2'd0, 0,0,0,0,0);
    cyc("lw_mem0",  LW, 0, 0,1,0, 3'd3, 0,2'd0, 0,0,1,0,0);
    cyc("lw_mem1",  LW, 0, 0,1,0, 3'd3, 0,2'd0, 0,0,1,0,0);
    cyc("lw_mem2",  LW, 0, 0,1,0, 3'd3, 0,2'd0, 0,0,1,0,0);
    cyc("lw_mem3",  LW, 0, 0,1,1, 3'd3, 0,2'd0, 0,0,1,0,0);
    cyc("lw_wb",    LW, 0, 0,1,1, 3'd4, 1,2'd0, 0,1,0,0,0);
    cyc("sw_if",    SW, 0, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    cyc("sw_id",    SW, 0, 0,1,0, 3'd1, 0,2'd0, 0,0,0,0,0);
    cyc("sw_exe",   SW, 0, 0,1,0, 3'd2, 0,2'd0, 0,0,0,0,0);
    cyc("sw_mem0",  SW, 0, 0,1,0, 3'd3, 0,2'd0, 0,0,0,1,0);
    cyc("sw_mem1",  SW, 0, 0,1,1, 3'd3, 1,2'd0, 0,0,0,1,0);
    // j, jal, jr: two cycles each
    cyc("j_if",     J_OP, 0, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    cyc("j_id",     J_OP, 0, 0,1,0, 3'd1, 1,2'd3, 0,0,0,0,0);
    cyc("jal_if",   JAL, 0, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    cyc("jal_id",   JAL, 0, 0,1,0, 3'd1, 1,2'd3, 0,1,0,0,0);
    cyc("jr_if",    R_OP, FJR, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    cyc("jr_id",    R_OP, FJR, 0,1,0, 3'd1, 1,2'd2, 0,0,0,0,0);
    cyc("ill_if",   ILL, 0, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    cyc("ill_id",   ILL, 0, 0,1,0, 3'd1, 1,2'd0, 0,0,0,0,0);
    cyc("radd_if",  R_OP, FADD, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    cyc("radd_id",  R_OP, FADD, 0,1,0, 3'd1, 0,2'd0, 0,0,0,0,0);
    cyc("radd_exe", R_OP, FADD, 0,1,0, 3'd2, 0,2'd0, 0,0,0,0,0);
    cyc("radd_wb",  R_OP, FADD, 0,1,0, 3'd4, 1,2'd0, 0,1,0,0,0);
    cyc("ori_if",   ORI, 0, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    cyc("ori_id",   ORI, 0, 0,1,0, 3'd1, 0,2'd0, 0,0,0,0,0);
    cyc("ori_exe",  ORI, 0, 0,1,0, 3'd2, 0,2'd0, 0,0,0,0,0);
    cyc("ori_wb",   ORI, 0, 0,1,0, 3'd4, 1,2'd0, 0,1,0,0,0);
    cyc("cnt_if",   LW, 0, 0,0,0, 3'd0, 0,2'd0, 0,0,0,0,0);
    // Abort an lw stalled in MEM; it must not be counted
    cyc("ab_if",    LW, 0, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    cyc("ab_id",    LW, 0, 0,1,0, 3'd1, 0,2'd0, 0,0,0,0,0);
    cyc("ab_exe",   LW, 0, 0,1,0, 3'd2, 0,2'd0, 0,0,0,0,0);
    cyc("ab_mem",   LW, 0, 0,1,0, 3'd3, 0,2'd0, 0,0,1,0,0);
    rst_cyc("ab_rst");
    cyc("ab2_if",   ADDI, 0, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    cyc("ab2_id",   ADDI, 0, 0,1,0, 3'd1, 0,2'd0, 0,0,0,0,0);
    cyc("ab2_exe",  ADDI, 0, 0,1,0, 3'd2, 0,2'd0, 0,0,0,0,0);
    cyc("ab2_wb",   ADDI, 0, 0,1,0, 3'd4, 1,2'd0, 0,1,0,0,0);
    // halt is absorbing
    cyc("hlt_if",   HLT, 0, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    cyc("hlt_id",   HLT, 0, 0,1,0, 3'd1, 0,2'd0, 0,0,0,0,0);
    for (int i = 0; i < 20; i++) begin
      cyc("hlt_hold", (i % 2 == 0) ? LW : SW, 0, i[0], i[1], i[2], 3'd7, 0,2'd0, 0,0,0,0,1);
    end
    rst_cyc("hlt_rst");
    cyc("post_if",  ADDI, 0, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
`ifdef PC_ALIGN_CHECK_EN
    cyc("al_if",    R_OP, FJR, 0,1,0, 3'd0, 0,2'd0, 0,0,0,0,0);
    @(posedge CLK); #1;
    q.pop_back();
    exp_ret = exp_ret;
    // re-issue the IF cycle of a fresh jr: the previous addi fetch left the FSM in ID
    rst_cyc("al_rst0");
    cyc("al_if2",   R_OP, FJR, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    regSrcLow = 2'b10;
    cyc("al_id",    R_OP, FJR, 0,1,0, 3'd1, 0,2'd0, 0,0,0,0,0);
    exp_aerr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc("al_halt", R_OP, FJR, 0,1,1, 3'd7, 0,2'd0, 0,0,0,0,1);
    end
    rst_cyc("al_rst");
    regSrcLow = 2'b00;
    cyc("alok_if",  R_OP, FJR, 0,1,0, 3'd0, 0,2'd0, 1,0,0,0,0);
    cyc("alok_id",  R_OP, FJR, 0,1,0, 3'd1, 1,2'd2, 0,0,0,0,0);
    cyc("alok_nx",  R_OP, FJR, 0,0,0, 3'd0, 0,2'd0, 0,0,0,0,0);
`endif
    @(posedge CLK); #1;
    Reset = 1'b1; imemReady = 1'b0; dmemReady = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    @(posedge CLK);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
